card_list_engine: RTL and testbench
===================================

Name: card_list_engine

Overview:
- Parametrised linked-list card store: NUM_LISTS independent card lists (hands/decks) share one node RAM and one hardware free list.
- Supports insert at head, remove-nth with card return, clear list, and count query.
- Serialised command/response handshake with internal state machine.
- Sits between game control FSM and card RAM; replaces ad-hoc store/remove/nth logic.

Parameters:
- ADDR_W, 10, node address width; DEPTH = 2**ADDR_W nodes; address 0 is NULL, so usable nodes are 1..DEPTH-1.
- VALUE_W, 4, card value width.
- SUIT_W, 2, card suit width.
- NUM_LISTS, 4, number of independent lists.
- LIST_W, 2, list-id width; must satisfy 2**LIST_W >= NUM_LISTS.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle; command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  operation: 00 INSERT, 01 REMOVE_NTH, 10 CLEAR, 11 COUNT.
- cmd_list  in  LIST_W  target list.
- cmd_n  in  ADDR_W  index for REMOVE_NTH; 0 = head.
- cmd_value  in  VALUE_W  card value for INSERT.
- cmd_suit  in  SUIT_W  card suit for INSERT.
- resp_valid  out  1  single-cycle completion pulse; no backpressure.
- resp_err  out  1  command rejected; no state change.
- resp_value  out  VALUE_W  removed card value (REMOVE_NTH).
- resp_suit  out  SUIT_W  removed card suit (REMOVE_NTH).
- resp_addr  out  ADDR_W  node written (INSERT) or freed (REMOVE_NTH).
- resp_count  out  ADDR_W  list count after the operation.
- free_count  out  ADDR_W  nodes on the free list.

Behaviour:
- Node word: {value, suit, next[ADDR_W-1:0]}. Single-port RAM, synchronous read, 1-cycle latency. Per-list head and count registers; free_head register.
- Reset: all outputs 0, cmd_ready 0, heads NULL, counts 0; enter INIT. Reset mid-operation abandons the command with no resp_valid.
- INIT: writes node k.next = k+1 for k = 1..DEPTH-2, then node DEPTH-1.next = NULL; sets free_head = 1 and free_count = DEPTH-1. Takes DEPTH-1 cycles, then IDLE with cmd_ready = 1.
- cmd_ready is 1 only in IDLE. Commands presented while busy are ignored. One command is outstanding at a time.
- Error checks, evaluated at accept and giving resp_valid 1 cycle later with resp_err = 1:
  - cmd_list >= NUM_LISTS.
  - INSERT with free_count == 0.
  - REMOVE_NTH with cmd_n >= count.
- INSERT: FREAD reads free_head node; IWRITE writes {value, suit, old head} at free_head; head = free_head, free_head = read next, count+1, free_count-1. resp_valid exactly 3 cycles after the accept edge, with resp_addr = new node.
- REMOVE_NTH: walk from head n hops, 2 cycles per hop (read, capture), tracking prev.
  - Unlink: n == 0 sets head = node.next; otherwise rewrite prev.next = node.next.
  - Push node onto free list: node.next = free_head, free_head = node. count-1, free_count+1.
  - resp_valid no later than 2n+6 cycles after accept.
- CLEAR: walk the list; each node is pushed onto the free list. count = 0, head = NULL. Clearing an empty list gives resp_valid 1 cycle after accept with no error.
- COUNT: resp_valid 1 cycle after accept, resp_count = count.
- resp_* data holds until the next resp_valid. count and free_count never wrap; error checks guarantee this.
- Invariant: sum of counts + free_count == DEPTH-1 at every IDLE.

Test Plan (ADDR_W=3, DEPTH=8, 7 usable nodes):
- Reset, then hold: cmd_ready rises after 7 cycles, free_count = 7. COUNT on list 0 -> resp_count 0, resp_err 0.
- INSERT (v=5, s=2) to list 1 -> resp_valid 3 cycles after accept, resp_addr 1, resp_count 1, free_count 6.
- INSERT v=1,2,3 to list 0, then REMOVE_NTH n=1 -> resp_value 2. Second REMOVE_NTH n=1 -> resp_value 1. COUNT -> 1.
- Fill all 7 nodes, then an 8th INSERT -> resp_err 1, free_count 0, counts unchanged. REMOVE_NTH n=7 on a list of 3 -> resp_err 1.
- CLEAR a 4-node list -> resp_count 0, free_count +4. Re-INSERT reuses a freed address; resp_addr ≠ 0.
- Assert reset during a REMOVE_NTH walk -> no resp_valid. Re-INIT completes; all counts 0, free_count 7.

Source files
------------

// File: rtl/card_list_engine.sv
// Linked-list card store: NUM_LISTS card lists sharing one node RAM and a hardware free list.
// Serialised command/response engine; one command outstanding at a time.
module card_list_engine #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned VALUE_W   = 4,
   parameter int unsigned SUIT_W    = 2,
   parameter int unsigned NUM_LISTS = 4,
   parameter int unsigned LIST_W    = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LIST_W-1:0]  cmd_list,
   input  logic [ADDR_W-1:0]  cmd_n,
   input  logic [VALUE_W-1:0] cmd_value,
   input  logic [SUIT_W-1:0]  cmd_suit,
   output logic               resp_valid,
   output logic               resp_err,
   output logic [VALUE_W-1:0] resp_value,
   output logic [SUIT_W-1:0]  resp_suit,
   output logic [ADDR_W-1:0]  resp_addr,
   output logic [ADDR_W-1:0]  resp_count,
   output logic [ADDR_W-1:0]  free_count
);

   localparam int unsigned DEPTH     = 1 << ADDR_W;
   localparam int unsigned NUM_SLOTS = 1 << LIST_W;
   localparam logic [ADDR_W-1:0] NULL_A = '0;
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

   localparam logic [1:0] OP_INSERT = 2'b00;
   localparam logic [1:0] OP_REMOVE = 2'b01;
   localparam logic [1:0] OP_CLEAR  = 2'b10;

   typedef struct packed {
      logic [VALUE_W-1:0] value;
      logic [SUIT_W-1:0]  suit;
      logic [ADDR_W-1:0]  next;
   } node_t;

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_FREAD, S_IWRITE, S_RREAD, S_RCAP,
      S_RUNLINK, S_RFREE, S_CREAD, S_CCAP, S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [1:0]         op_q, op_d;
   logic [LIST_W-1:0]  list_q, list_d;
   logic [ADDR_W-1:0]  hop_q, hop_d;
   logic [VALUE_W-1:0] val_q, val_d, pval_q, pval_d;
   logic [SUIT_W-1:0]  suit_q, suit_d, psuit_q, psuit_d;
   logic               err_q, err_d;
   logic [ADDR_W-1:0]  cur_q, cur_d, prev_q, prev_d, nxt_q, nxt_d;
   logic [ADDR_W-1:0]  free_head_q, free_head_d, free_cnt_q, free_cnt_d;
   logic [ADDR_W-1:0]  head_q [NUM_SLOTS];
   logic [ADDR_W-1:0]  head_d [NUM_SLOTS];
   logic [ADDR_W-1:0]  cnt_q  [NUM_SLOTS];
   logic [ADDR_W-1:0]  cnt_d  [NUM_SLOTS];

   logic               cmd_ready_q;
   logic               resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
   logic [VALUE_W-1:0] resp_value_q, resp_value_d;
   logic [SUIT_W-1:0]  resp_suit_q, resp_suit_d;
   logic [ADDR_W-1:0]  resp_addr_q, resp_addr_d, resp_count_q, resp_count_d;

   node_t              mem [DEPTH];
   node_t              mem_rdata, mem_wdata;
   logic               mem_we, mem_re;
   logic [ADDR_W-1:0]  mem_addr;

   // Single-port node RAM, synchronous read
   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      list_d       = list_q;
      hop_d        = hop_q;
      val_d        = val_q;
      suit_d       = suit_q;
      pval_d       = pval_q;
      psuit_d      = psuit_q;
      err_d        = err_q;
      cur_d        = cur_q;
      prev_d       = prev_q;
      nxt_d        = nxt_q;
      free_head_d  = free_head_q;
      free_cnt_d   = free_cnt_q;
      head_d       = head_q;
      cnt_d        = cnt_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_value_d = resp_value_q;
      resp_suit_d  = resp_suit_q;
      resp_addr_d  = resp_addr_q;
      resp_count_d = resp_count_q;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      mem_addr     = cur_q;
      mem_wdata    = '0;

      case (state_q)
         // Chain every node onto the free list; last node's +1 wraps to NULL
         S_INIT: begin
            mem_we    = 1'b1;
            mem_wdata = {VALUE_W'(0), SUIT_W'(0), cur_q + ONE_A};
            if (cur_q == LAST_A) begin
               state_d     = S_IDLE;
               free_head_d = ONE_A;
               free_cnt_d  = LAST_A;
               cur_d       = NULL_A;
            end else begin
               cur_d = cur_q + ONE_A;
            end
         end
         S_IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               list_d  = cmd_list;
               hop_d   = cmd_n;
               val_d   = cmd_value;
               suit_d  = cmd_suit;
               err_d   = 1'b0;
               prev_d  = NULL_A;
               cur_d   = head_q[cmd_list];
               state_d = S_DONE;
               if (32'(cmd_list) >= NUM_LISTS) begin
                  err_d = 1'b1;
               end else begin
                  case (cmd_op)
                     OP_INSERT: begin
                        if (free_cnt_q == NULL_A) err_d = 1'b1;
                        else begin
                           cur_d   = free_head_q;
                           state_d = S_FREAD;
                        end
                     end
                     OP_REMOVE: begin
                        if (cmd_n >= cnt_q[cmd_list]) err_d = 1'b1;
                        else state_d = S_RREAD;
                     end
                     OP_CLEAR: begin
                        if (cnt_q[cmd_list] != NULL_A) state_d = S_CREAD;
                     end
                     default: ;
                  endcase
               end
            end
         end
         S_FREAD: begin
            mem_re  = 1'b1;
            state_d = S_IWRITE;
         end
         S_IWRITE: begin
            mem_we         = 1'b1;
            mem_wdata      = {val_q, suit_q, head_q[list_q]};
            head_d[list_q] = cur_q;
            cnt_d[list_q]  = cnt_q[list_q] + ONE_A;
            free_head_d    = mem_rdata.next;
            free_cnt_d     = free_cnt_q - ONE_A;
            state_d        = S_DONE;
         end
         S_RREAD: begin
            mem_re  = 1'b1;
            state_d = S_RCAP;
         end
         // Either stop on the target node or step forward, remembering the predecessor's card
         S_RCAP: begin
            nxt_d = mem_rdata.next;
            if (hop_q == NULL_A) begin
               val_d   = mem_rdata.value;
               suit_d  = mem_rdata.suit;
               state_d = S_RUNLINK;
            end else begin
               prev_d  = cur_q;
               pval_d  = mem_rdata.value;
               psuit_d = mem_rdata.suit;
               cur_d   = mem_rdata.next;
               hop_d   = hop_q - ONE_A;
               state_d = S_RREAD;
            end
         end
         S_RUNLINK: begin
            if (prev_q == NULL_A) begin
               head_d[list_q] = nxt_q;
            end else begin
               mem_we    = 1'b1;
               mem_addr  = prev_q;
               mem_wdata = {pval_q, psuit_q, nxt_q};
            end
            state_d = S_RFREE;
         end
         S_RFREE: begin
            mem_we        = 1'b1;
            mem_wdata     = {val_q, suit_q, free_head_q};
            free_head_d   = cur_q;
            cnt_d[list_q] = cnt_q[list_q] - ONE_A;
            free_cnt_d    = free_cnt_q + ONE_A;
            state_d       = S_DONE;
         end
         S_CREAD: begin
            mem_re  = 1'b1;
            state_d = S_CCAP;
         end
         S_CCAP: begin
            mem_we        = 1'b1;
            mem_wdata     = {mem_rdata.value, mem_rdata.suit, free_head_q};
            free_head_d   = cur_q;
            cnt_d[list_q] = cnt_q[list_q] - ONE_A;
            free_cnt_d    = free_cnt_q + ONE_A;
            if (mem_rdata.next == NULL_A) begin
               head_d[list_q] = NULL_A;
               state_d        = S_DONE;
            end else begin
               cur_d   = mem_rdata.next;
               state_d = S_CREAD;
            end
         end
         S_DONE: begin
            resp_valid_d = 1'b1;
            resp_err_d   = err_q;
            resp_count_d = cnt_q[list_q];
            if (!err_q && (op_q == OP_INSERT || op_q == OP_REMOVE)) resp_addr_d = cur_q;
            if (!err_q && op_q == OP_REMOVE) begin
               resp_value_d = val_q;
               resp_suit_d  = suit_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (reset) mem_we = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_INIT;
         op_q         <= '0;
         list_q       <= '0;
         hop_q        <= '0;
         val_q        <= '0;
         suit_q       <= '0;
         pval_q       <= '0;
         psuit_q      <= '0;
         err_q        <= 1'b0;
         cur_q        <= ONE_A;
         prev_q       <= '0;
         nxt_q        <= '0;
         free_head_q  <= '0;
         free_cnt_q   <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            head_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         cmd_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_value_q <= '0;
         resp_suit_q  <= '0;
         resp_addr_q  <= '0;
         resp_count_q <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         list_q       <= list_d;
         hop_q        <= hop_d;
         val_q        <= val_d;
         suit_q       <= suit_d;
         pval_q       <= pval_d;
         psuit_q      <= psuit_d;
         err_q        <= err_d;
         cur_q        <= cur_d;
         prev_q       <= prev_d;
         nxt_q        <= nxt_d;
         free_head_q  <= free_head_d;
         free_cnt_q   <= free_cnt_d;
         head_q       <= head_d;
         cnt_q        <= cnt_d;
         cmd_ready_q  <= (state_d == S_IDLE);
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_value_q <= resp_value_d;
         resp_suit_q  <= resp_suit_d;
         resp_addr_q  <= resp_addr_d;
         resp_count_q <= resp_count_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_value = resp_value_q;
   assign resp_suit  = resp_suit_q;
   assign resp_addr  = resp_addr_q;
   assign resp_count = resp_count_q;
   assign free_count = free_cnt_q;

endmodule

// File: tb/tb_card_list_engine.sv
// Scoreboard bench for card_list_engine with an 8-node RAM (7 usable nodes).
module tb_card_list_engine;

   localparam int unsigned ADDR_W    = 3;
   localparam int unsigned VALUE_W   = 4;
   localparam int unsigned SUIT_W    = 2;
   localparam int unsigned NUM_LISTS = 4;
   localparam int unsigned LIST_W    = 2;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic [1:0]         cmd_op = '0;
   logic [LIST_W-1:0]  cmd_list = '0;
   logic [ADDR_W-1:0]  cmd_n = '0;
   logic [VALUE_W-1:0] cmd_value = '0;
   logic [SUIT_W-1:0]  cmd_suit = '0;
   logic               resp_valid, resp_err;
   logic [VALUE_W-1:0] resp_value;
   logic [SUIT_W-1:0]  resp_suit;
   logic [ADDR_W-1:0]  resp_addr, resp_count, free_count;

   card_list_engine #(
      .ADDR_W(ADDR_W), .VALUE_W(VALUE_W), .SUIT_W(SUIT_W),
      .NUM_LISTS(NUM_LISTS), .LIST_W(LIST_W)
   ) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_list(cmd_list), .cmd_n(cmd_n), .cmd_value(cmd_value), .cmd_suit(cmd_suit),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_value(resp_value),
      .resp_suit(resp_suit), .resp_addr(resp_addr), .resp_count(resp_count),
      .free_count(free_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      string name;
      bit    err;
      bit    chk_addr;
      bit    chk_card;
      int    value;
      int    suit;
      int    addr;
      int    count;
      int    fc;
      int    lat_min;
      int    lat_max;
      int    acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t mon_e;
   int   mon_lat;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pop the oldest expectation on every response pulse
   always @(negedge clock) begin
      if (resp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_valid 1 expected no response (cycle %0d)", cyc);
         end else begin
            mon_e   = sb.pop_front();
            mon_lat = cyc - mon_e.acc;
            checks++;
            if (mon_lat < mon_e.lat_min || mon_lat > mon_e.lat_max) begin
               errors++;
               $display("FAIL %s_latency: got %0d expected %0d..%0d", mon_e.name, mon_lat,
                        mon_e.lat_min, mon_e.lat_max);
            end
            chk({mon_e.name, "_err"}, int'(resp_err), int'(mon_e.err));
            chk({mon_e.name, "_count"}, int'(resp_count), mon_e.count);
            chk({mon_e.name, "_free"}, int'(free_count), mon_e.fc);
            if (mon_e.chk_addr) chk({mon_e.name, "_addr"}, int'(resp_addr), mon_e.addr);
            if (mon_e.chk_card) begin
               chk({mon_e.name, "_value"}, int'(resp_value), mon_e.value);
               chk({mon_e.name, "_suit"}, int'(resp_suit), mon_e.suit);
            end
         end
      end
   end

   function automatic exp_t mk(input string name, input bit err, input bit ca, input bit cc,
                               input int v, input int s, input int a, input int cnt, input int fc,
                               input int lmin, input int lmax);
      exp_t e;
      e.name = name; e.err = err; e.chk_addr = ca; e.chk_card = cc;
      e.value = v; e.suit = s; e.addr = a; e.count = cnt; e.fc = fc;
      e.lat_min = lmin; e.lat_max = lmax; e.acc = 0;
      return e;
   endfunction

   task automatic issue(input logic [1:0] op, input int list, input int n, input int v, input int s,
                        input bit expect_resp, input exp_t e);
      int w = 0;
      @(negedge clock);
      while (cmd_ready !== 1'b1 && w < 300) begin
         @(negedge clock);
         w++;
      end
      if (cmd_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_ready_timeout: got cmd_ready %b expected 1", e.name, cmd_ready);
         return;
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_list  = LIST_W'(list);
      cmd_n     = ADDR_W'(n);
      cmd_value = VALUE_W'(v);
      cmd_suit  = SUIT_W'(s);
      if (expect_resp) begin
         e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clock);
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic do_insert(input string name, input int list, input int v, input int s,
                            input int addr, input int cnt, input int fc);
      issue(2'b00, list, 0, v, s, 1'b1, mk(name, 1'b0, 1'b1, 1'b0, 0, 0, addr, cnt, fc, 3, 3));
   endtask

   task automatic do_remove(input string name, input int list, input int n, input int v,
                            input int s, input int addr, input int cnt, input int fc);
      issue(2'b01, list, n, 0, 0, 1'b1,
            mk(name, 1'b0, 1'b1, 1'b1, v, s, addr, cnt, fc, 1, 2 * n + 6));
   endtask

   task automatic do_error(input string name, input logic [1:0] op, input int list, input int n,
                           input int cnt, input int fc);
      issue(op, list, n, 0, 0, 1'b1, mk(name, 1'b1, 1'b0, 1'b0, 0, 0, 0, cnt, fc, 1, 1));
   endtask

   task automatic do_clear(input string name, input int list, input int fc, input int lmax);
      issue(2'b10, list, 0, 0, 0, 1'b1, mk(name, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, fc, 1, lmax));
   endtask

   task automatic do_count(input string name, input int list, input int cnt, input int fc);
      issue(2'b11, list, 0, 0, 0, 1'b1, mk(name, 1'b0, 1'b0, 1'b0, 0, 0, 0, cnt, fc, 1, 1));
   endtask

   // Count cycles from reset release until cmd_ready is seen
   task automatic wait_init(input string name);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (cmd_ready !== 1'b1 && n < 100);
      chk({name, "_cycles"}, n, 7);
      chk({name, "_free"}, int'(free_count), 7);
   endtask

   initial begin
      int w;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_ready", int'(cmd_ready), 0);
      chk("rst_resp_valid", int'(resp_valid), 0);
      chk("rst_free", int'(free_count), 0);
      chk("rst_resp_count", int'(resp_count), 0);
      reset = 1'b0;
      wait_init("init");

      do_count("count_l0_empty", 0, 0, 7);
      do_insert("ins_l1", 1, 5, 2, 1, 1, 6);
      do_insert("ins_l0_v1", 0, 1, 0, 2, 1, 5);
      do_insert("ins_l0_v2", 0, 2, 1, 3, 2, 4);
      do_insert("ins_l0_v3", 0, 3, 3, 4, 3, 3);
      do_remove("rem_mid_a", 0, 1, 2, 1, 3, 2, 4);
      do_remove("rem_mid_b", 0, 1, 1, 0, 2, 1, 5);
      do_count("count_l0", 0, 1, 5);

      do_insert("fill_l2_a", 2, 6, 0, 2, 1, 4);
      do_insert("fill_l2_b", 2, 7, 1, 3, 2, 3);
      do_insert("fill_l2_c", 2, 8, 2, 5, 3, 2);
      do_insert("fill_l3_a", 3, 9, 3, 6, 1, 1);
      do_insert("fill_l3_b", 3, 10, 0, 7, 2, 0);
      do_error("ins_full", 2'b00, 3, 0, 2, 0);
      do_error("rem_n7", 2'b01, 2, 7, 3, 0);
      do_error("rem_n_eq_cnt", 2'b01, 2, 3, 3, 0);
      do_count("count_l2_kept", 2, 3, 0);

      do_remove("rem_tail", 2, 2, 6, 0, 2, 2, 1);
      do_remove("rem_head", 0, 0, 3, 3, 4, 0, 2);
      do_insert("ins_l3_c", 3, 12, 1, 4, 3, 1);
      do_insert("ins_l3_d", 3, 13, 2, 2, 4, 0);
      do_clear("clear_l3", 3, 4, 12);
      do_clear("clear_empty", 0, 4, 1);
      do_count("count_l3_cleared", 3, 0, 4);
      do_insert("ins_reuse", 0, 14, 3, 6, 1, 3);
      do_remove("rem_reuse", 0, 0, 14, 3, 6, 0, 4);
      do_insert("ins_l1_b", 1, 1, 1, 6, 2, 3);
      do_insert("ins_l1_c", 1, 2, 2, 7, 3, 2);

      // Abandon a walk with reset; no response may follow
      issue(2'b01, 1, 2, 0, 0, 1'b0, mk("rem_abort", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("abort_resp_valid", int'(resp_valid), 0);
      chk("abort_ready", int'(cmd_ready), 0);
      chk("abort_free", int'(free_count), 0);
      reset = 1'b0;
      wait_init("reinit");
      for (int l = 0; l < 4; l++) do_count($sformatf("reinit_count_l%0d", l), l, 0, 7);
      do_insert("reinit_ins", 2, 15, 3, 1, 1, 6);

      w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(negedge clock);
         w++;
      end
      chk("sb_drain", sb.size(), 0);
      repeat (3) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
